// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the multiplier datapath and its BCD readout stage.
// Holds the converter state encoding and the double-dabble adjust constants.
package mult_pkg;

    localparam int PRODUCT_W   = 16;
    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } conv_state_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Bus between the multiplier (master) and the BCD converter (slave).
// The master drives ready/product and observes the converter's result.
interface product_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  ready;
    logic [WIDTH-1:0]      product;
    logic                  busy;
    logic                  valid;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output ready,
        output product,
        input  busy,
        input  valid,
        input  bcd
    );

    modport slave (
        input  ready,
        input  product,
        output busy,
        output valid,
        output bcd
    );
endinterface

// File: rtl/product_bcd_converter_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import mult_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] in_i,
    output logic [BCD_DIGIT_W-1:0] out_o
);
    always_comb begin
        out_o = in_i;
        if (in_i >= ADJ_THRESH) begin
            out_o = in_i + ADJ_ADD;
        end
    end
endmodule

// File: rtl/product_bcd_converter.sv
// Captures the multiplier product on a rising ready and converts it to packed
// BCD with a one-bit-per-clock double-dabble; result held with a valid flag.
module product_bcd_converter
    import mult_pkg::*;
#(
    parameter int WIDTH  = PRODUCT_W,
    parameter int DIGITS = 5
) (
    input  logic clock,
    input  logic nreset,
    product_bcd_converter_if.slave bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t          state_q, state_d;
    logic                 ready_prev_q;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]     acc_q, acc_d;
    logic [BCD_W-1:0]     acc_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 start_evt;

    assign start_evt = bus.ready & ~ready_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .in_i  (acc_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .out_o (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            ready_prev_q <= 1'b0;
            bin_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            bcd_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_prev_q <= bus.ready;
            bin_q        <= bin_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            bcd_q        <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        bcd_d   = bcd_q;

        unique case (state_q)
            IDLE: begin
                if (start_evt) begin
                    bin_d   = bus.product;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // Adjust first, then shift the binary MSB into the BCD LSB.
                {acc_d, bin_d} = {acc_adj, bin_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.bcd   = bcd_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomised and directed bench for product_bcd_converter with a decimal
// reference model and a per-cycle output comparison.
module tb_product_bcd_converter;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = WIDTH + 2;   // negedges from raising ready to valid

    logic clock;
    logic nreset;

    product_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_if ();

    product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Decimal conversion straight from the definition of base-10 digits.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Timing model: a capture starts a countdown; result appears when it expires.
    logic                m_prev, m_busy, m_valid;
    logic [4*DIGITS-1:0] m_bcd;
    int unsigned         m_val;
    int                  m_left;

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            m_prev  <= 1'b0;
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_val   <= 0;
            m_left  <= 0;
        end else begin
            m_prev <= u_if.ready;
            if (!m_busy) begin
                if (u_if.ready && !m_prev) begin
                    m_busy  <= 1'b1;
                    m_valid <= 1'b0;
                    m_val   <= u_if.product;
                    m_left  <= WIDTH + 1;
                end
            end else begin
                if (m_left == 1) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_bcd   <= to_bcd(m_val);
                end
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_busy",  {31'd0, u_if.busy},  {31'd0, m_busy});
            chk("cyc_valid", {31'd0, u_if.valid}, {31'd0, m_valid});
            chk("cyc_bcd",   32'(u_if.bcd),       32'(m_bcd));
        end
    end

    // mode 1: re-trigger while busy; mode 2: previous result must be held while busy
    task automatic run(input string name, input logic [15:0] p, input logic [19:0] exp,
                       input int mode, input logic [19:0] prev);
        int  n;
        bit  seen;
        u_if.ready = 1'b0;
        @(negedge clock);
        u_if.product = p;
        u_if.ready   = 1'b1;
        seen = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (n == 2) u_if.product = 16'($urandom);
            if (mode == 1 && n == 5) u_if.ready = 1'b0;
            if (mode == 1 && n == 6) begin
                u_if.ready   = 1'b1;
                u_if.product = 16'h0001;
            end
            if (mode == 2 && n == 5) begin
                chk({name, "_held_bcd"}, 32'(u_if.bcd), 32'(prev));
                chk({name, "_held_valid"}, {31'd0, u_if.valid}, 32'd0);
            end
            if (u_if.valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_latency"}, seen ? 32'(n) : 32'hFFFF, 32'(LAT));
        chk({name, "_bcd"}, 32'(u_if.bcd), 32'(exp));
        $display("conv %s: product=%0d bcd=%05h edges=%0d", name, p, u_if.bcd, n);
        u_if.ready = 1'b0;
    endtask

    initial begin
        int good_valid;
        nreset       = 1'b0;
        u_if.ready   = 1'b0;
        u_if.product = '0;

        // Pin the reference model against hand-computed values.
        chk("model_2783", 32'(to_bcd(32'h2783)), 32'h10115);
        chk("model_ffff", 32'(to_bcd(32'hFFFF)), 32'h65535);
        chk("model_9999", 32'(to_bcd(9999)),     32'h09999);

        repeat (3) @(negedge clock);
        chk("rst_busy",  {31'd0, u_if.busy},  32'd0);
        chk("rst_valid", {31'd0, u_if.valid}, 32'd0);
        chk("rst_bcd",   32'(u_if.bcd),       32'd0);
        nreset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clock);

        run("nominal", 16'h2783, 20'h10115, 0, 20'h0);
        run("zero",    16'h0000, 20'h00000, 0, 20'h0);
        run("max",     16'hFFFF, 20'h65535, 0, 20'h0);
        run("d9999",   16'd9999, 20'h09999, 0, 20'h0);
        run("retrig",  16'h2783, 20'h10115, 1, 20'h0);

        // Abort on the 8th CONVERT cycle; reset must act without a clock edge.
        @(negedge clock);
        u_if.product = 16'd4242;
        u_if.ready   = 1'b1;
        repeat (8) @(negedge clock);
        #2;
        nreset = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, u_if.busy},  32'd0);
        chk("abort_valid", {31'd0, u_if.valid}, 32'd0);
        chk("abort_bcd",   32'(u_if.bcd),       32'd0);
        $display("abort: reset applied mid-conversion busy=%0b valid=%0b bcd=%05h",
                 u_if.busy, u_if.valid, u_if.bcd);
        u_if.ready = 1'b0;
        @(negedge clock);
        nreset = 1'b1;
        good_valid = 0;
        repeat (25) begin
            @(negedge clock);
            if (u_if.valid) good_valid++;
        end
        chk("abort_no_valid", 32'(good_valid), 32'd0);
        run("after_abort", 16'd100, 20'h00100, 0, 20'h0);

        run("b2b_first",  16'd1234, 20'h01234, 0, 20'h0);
        run("b2b_second", 16'd4321, 20'h04321, 2, 20'h01234);

        // Random ready/product traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            u_if.product = 16'($urandom);
            if ($urandom_range(0, 3) == 0) u_if.ready = ~u_if.ready;
            if (i % 50 == 49) $display("random: cycle %0d busy=%0b valid=%0b bcd=%05h",
                                       i, u_if.busy, u_if.valid, u_if.bcd);
        end
        u_if.ready = 1'b0;
        repeat (25) @(negedge clock);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
Downstream stage of the shift-add multiplier. Captures the 16-bit product AQ when the multiplier's ready output rises, converts it to packed BCD using a sequential double-dabble algorithm (one bit per clock), and presents the stable decimal digits to the display/readout stage with a valid flag. It runs on the same slow clock as the multiplier's sequencer.

Parameters:
WIDTH, 16, binary input width; must match the AQ width.
DIGITS, 5, number of BCD output digits; must be >= ceil(WIDTH*log10(2)), which gives 5 for WIDTH=16.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
nreset  input  1  asynchronous active-low reset; takes effect immediately, releases synchronously to clock.
ready  input  1  multiplier ready level; a 0->1 transition requests a conversion.
product  input  WIDTH  binary product (AQ); sampled only on the capture cycle.
busy  output  1  high while a conversion is in progress.
valid  output  1  high while bcd holds a completed conversion.
bcd  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0], least significant.

Behaviour:
- Reset (nreset=0, asynchronous): state=IDLE, busy=0, valid=0, bcd=0, shift register=0, bit counter=0, ready_d (previous-ready flop)=0.
- Edge detect: start_evt = ready & ~ready_d. ready_d updates every clock.
  - ready high at reset release with ready_d=0 produces one start_evt. This is intended.
- States:
  - IDLE: on start_evt, load product into the binary shift register, clear the BCD accumulator, set counter=WIDTH, go to CONVERT, busy=1.
  - CONVERT: each cycle, for every accumulator digit >=5 add 3 (4-bit, no carry between digits), then shift {accumulator, binary} left by 1 and decrement counter. When counter reaches 1 on this cycle, go to DONE.
  - DONE: one cycle. Copy accumulator to bcd, set valid=1, busy=0, return to IDLE.
- Latency: start_evt in cycle N -> busy from N+1 -> bcd/valid updated at the edge ending cycle N+WIDTH+1. For WIDTH=16, valid asserts 18 edges after the edge that sampled ready=1.
- valid behaviour:
  - Stays 1 until the next start_evt.
  - On start_evt, valid drops to 0 in the same edge that sets busy=1.
  - The previous bcd value is retained, not cleared, until DONE overwrites it.
- start_evt during CONVERT or DONE is ignored (no restart, no queuing). The multiplier cannot legally produce one, because ready stays low for more than WIDTH cycles.
- product changing after the capture cycle has no effect.
- Boundary values:
  - product=0 -> bcd all zeros.
  - product=2^WIDTH-1 -> 65535 for WIDTH=16.
  - Unused upper digits are always 0.
- nreset asserted mid-conversion aborts immediately to the reset values. No partial result is ever flagged valid.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package mult_pkg holds:
  - conv_state_t enum {IDLE, CONVERT, DONE}
  - BCD_DIGIT_W=4
  - ADJ_THRESH=4'd5, ADJ_ADD=4'd3
  - PRODUCT_W=16 (shared with the multiplier)
- One sub-module, bcd_digit_adj: purely combinational, 4-bit in / 4-bit out (in>=5 ? in+3 : in). Instantiated DIGITS times through a generate loop.

Test Plan:
- Reset: pulse nreset low mid-simulation -> busy=0, valid=0, bcd=20'h00000 immediately, without waiting for a clock edge.
- Nominal: product=16'h2783 (85*119), raise ready -> busy for 17 cycles, then valid=1 with bcd=20'h10115 exactly 18 edges after ready was sampled.
- Extremes: product=16'h0000 -> bcd=20'h00000; product=16'hFFFF -> bcd=20'h65535; product=16'd9999 -> bcd=20'h09999.
- Ignored re-trigger: while busy, toggle ready 0->1 and change product to 16'h0001 -> the result is still that of the original product and latency is unchanged.
- Abort: assert nreset on the 8th CONVERT cycle, release, then convert 16'd100 -> valid never asserts for the aborted run; the next result is bcd=20'h00100.
- Back-to-back: two conversions (16'd1234, then 16'd4321) with ready dropping after the first valid -> valid drops for the second run, the first bcd value is held during it, and the final result is bcd=20'h04321.
